rtc_bus_responder: RTL and testbench
====================================

// Module: rtc_bus_responder
// PURPOSE
//  Behavioural/synthesizable responder for the multiplexed RTC bus (CS/RD/WR active-low, AD=0 address, AD=1 data).
//  Serves the bus master as the RTC device would, holding BCD time/date and a countdown timer in a register file.
//  Used as the FPGA-side RTC stand-in for bench and board bring-up of the RTC bus master.
// PARAMETERS
//  TICK_DIV   100_000_000  clk_i cycles per 1 s tick (>=2)
//  SYNC_STG   2            synchronizer flops on cs_n_i/rd_n_i/wr_n_i/ad_i (>=2)
// PORTS
//  clk_i          in   1  single clock
//  reset_i        in   1  synchronous, active-high reset
//  cs_n_i         in   1  chip select, active low
//  ad_i           in   1  0 = address phase, 1 = data phase
//  rd_n_i         in   1  read strobe, active low
//  wr_n_i         in   1  write strobe, active low
//  bus_i          in   8  bus value driven by master
//  bus_o          out  8  read data
//  bus_oe_o       out  1  1 = responder drives bus (tristate enable at top level)
//  timer_done_o   out  1  sticky, countdown reached 00:00:00
//  regseg..regano out  8 each  live BCD sec,min,hour,date,month,year
// BEHAVIOUR
//  - Reset: seg/min=00, hora=00, date=01, mes=01, ano=00, timer regs=00, addr_q=00, prescaler=0;
//    bus_o=00, bus_oe_o=0, timer_done_o=0.
//  - Strobes and ad_i pass SYNC_STG flops. bus_i is sampled unsynchronized on the write-commit cycle (stable per protocol).
//  - Write commit: rising edge of synced wr_n while synced cs_n=0.
//    ad=0 -> addr_q<=bus_i. ad=1 -> write reg[addr_q].
//  - Map:
//    0x21 seg, 0x22 min, 0x23 hora, 0x24 date, 0x25 mes, 0x26 ano.
//    0x41 Tseg, 0x42 Tmin, 0x43 Thora.
//    0xF1 write (any data) clears timer_done_o.
//    Other addresses: writes ignored, reads return 0x00.
//  - Written values are stored as-is, with no BCD validation.
//  - Read: bus_oe_o=1 exactly while synced cs_n=0 & rd_n=0 & ad=1.
//    bus_o=reg[addr_q], registered one cycle behind the select. Data is held stable while oe.
//    bus_oe_o=0 during address phase and whenever cs_n=1. WR and RD both low: write wins, oe=0.
//  - Prescaler 0..TICK_DIV-1; tick when it wraps.
//  - Tick: BCD increment seg.
//    Carries: 59->00 into min, 59->00 into hora, 23->00 into date.
//    date past month length -> 01, carry into mes. 12->01, carry into ano. 99->00.
//    Month length 31/30/28; Feb=29 when ano (BCD) divisible by 4.
//  - Timer: on tick, if {Thora,Tmin,Tseg}!=0, decrement BCD hh:mm:ss with borrow (00s->59, 00m->59).
//    On reaching 0, set timer_done_o. At 0 it holds.
//  - Simultaneous write commit and tick: the write to that register wins. The tick still updates all other registers.
//    A carry into the written register is dropped.
//  - Reset mid-transaction: bus_oe_o drops in the same cycle reset is sampled. The pending write is discarded.
// TESTING
//  1) Write addr 0x22 then data 0x45; read 0x22 -> bus_o=0x45 and regmin=0x45; bus_oe_o only in data-phase RD low.
//  2) Set 23:59:59 on 31/12/99; one tick -> 00:00:00 01/01/00.
//  3) Date 28/02 with ano=0x24 -> tick rollover gives 29/02.
//     With ano=0x23 -> 01/03.
//  4) Timer 00:01:00; 60 ticks -> 00:00:00, timer_done_o=1 and held; write addr 0xF1 -> timer_done_o=0.
//  5) Read unmapped 0x30 -> 0x00.
//     RD+WR low together -> bus_oe_o=0, write performed.
//     cs_n=1 strobes -> no effect.
//  6) Write seg=0x10 on tick cycle -> seg=0x10, min unchanged.
//     Assert reset during read -> bus_oe_o=0 next edge, all reset values.

Source files
------------

// File: rtl/rtc_bus_responder.sv
// RTC device stand-in on the multiplexed CS/RD/WR/AD bus: BCD time/date,
// a BCD countdown timer and a small addressed register file.
module rtc_bus_responder #(
   parameter int unsigned TICK_DIV = 100_000_000,
   parameter int unsigned SYNC_STG = 2
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       cs_n_i,
   input  logic       ad_i,
   input  logic       rd_n_i,
   input  logic       wr_n_i,
   input  logic [7:0] bus_i,
   output logic [7:0] bus_o,
   output logic       bus_oe_o,
   output logic       timer_done_o,
   output logic [7:0] regseg,
   output logic [7:0] regmin,
   output logic [7:0] reghora,
   output logic [7:0] regdate,
   output logic [7:0] regmes,
   output logic [7:0] regano
);
   localparam int unsigned DW = 8;
   localparam int unsigned PW = $clog2(TICK_DIV);

   typedef logic [DW-1:0] byte_t;

   function automatic byte_t bcd_inc(input byte_t v);
      return (v[3:0] == 4'h9) ? {v[7:4] + 4'h1, 4'h0} : v + 8'h01;
   endfunction

   function automatic byte_t bcd_dec(input byte_t v);
      return (v[3:0] == 4'h0) ? {v[7:4] - 4'h1, 4'h9} : v - 8'h01;
   endfunction

   logic [SYNC_STG-1:0] cs_sync_q, cs_sync_d, rd_sync_q, rd_sync_d;
   logic [SYNC_STG-1:0] wr_sync_q, wr_sync_d, ad_sync_q, ad_sync_d;
   logic                wr_prev_q, wr_prev_d;
   logic [PW-1:0]       presc_q, presc_d;
   byte_t               addr_q, addr_d;
   byte_t               seg_q, seg_d, min_q, min_d, hora_q, hora_d;
   byte_t               date_q, date_d, mes_q, mes_d, ano_q, ano_d;
   byte_t               tseg_q, tseg_d, tmin_q, tmin_d, thora_q, thora_d;
   logic                done_q, done_d;
   logic                oe_q, oe_d;
   byte_t               bus_q, bus_d;

   logic                cs_s, rd_s, wr_s, ad_s;
   logic                tick_c, commit_c, sel_c, leap_c;
   logic [3:0]          ysum_c;
   byte_t               mlen_c, rdata_c;

   assign cs_s = cs_sync_q[SYNC_STG-1];
   assign rd_s = rd_sync_q[SYNC_STG-1];
   assign wr_s = wr_sync_q[SYNC_STG-1];
   assign ad_s = ad_sync_q[SYNC_STG-1];

   // Register read mux, unmapped addresses read as zero
   always_comb begin
      rdata_c = 8'h00;
      case (addr_q)
         8'h21:   rdata_c = seg_q;
         8'h22:   rdata_c = min_q;
         8'h23:   rdata_c = hora_q;
         8'h24:   rdata_c = date_q;
         8'h25:   rdata_c = mes_q;
         8'h26:   rdata_c = ano_q;
         8'h41:   rdata_c = tseg_q;
         8'h42:   rdata_c = tmin_q;
         8'h43:   rdata_c = thora_q;
         default: rdata_c = 8'h00;
      endcase
   end

   // Last day of the current month; tens*10 mod 4 is 2 for odd tens digits
   always_comb begin
      ysum_c = ano_q[3:0] + (ano_q[4] ? 4'd2 : 4'd0);
      leap_c = (ysum_c[1:0] == 2'b00);
      case (mes_q)
         8'h02:                      mlen_c = leap_c ? 8'h29 : 8'h28;
         8'h04, 8'h06, 8'h09, 8'h11: mlen_c = 8'h30;
         default:                    mlen_c = 8'h31;
      endcase
   end

   always_comb begin
      cs_sync_d = {cs_sync_q[SYNC_STG-2:0], cs_n_i};
      rd_sync_d = {rd_sync_q[SYNC_STG-2:0], rd_n_i};
      wr_sync_d = {wr_sync_q[SYNC_STG-2:0], wr_n_i};
      ad_sync_d = {ad_sync_q[SYNC_STG-2:0], ad_i};
      wr_prev_d = wr_s;
      addr_d    = addr_q;
      seg_d     = seg_q;
      min_d     = min_q;
      hora_d    = hora_q;
      date_d    = date_q;
      mes_d     = mes_q;
      ano_d     = ano_q;
      tseg_d    = tseg_q;
      tmin_d    = tmin_q;
      thora_d   = thora_q;
      done_d    = done_q;
      bus_d     = bus_q;

      tick_c   = (presc_q == PW'(TICK_DIV - 1));
      presc_d  = tick_c ? '0 : presc_q + PW'(1);
      commit_c = wr_s && !wr_prev_q && !cs_s;
      sel_c    = !cs_s && !rd_s && ad_s && wr_s;
      oe_d     = sel_c;

      // Read data latched on the first selected cycle and held while driven
      if (sel_c && !oe_q) bus_d = rdata_c;

      if (tick_c) begin
         seg_d = bcd_inc(seg_q);
         if (seg_q == 8'h59) begin
            seg_d = 8'h00;
            min_d = bcd_inc(min_q);
            if (min_q == 8'h59) begin
               min_d  = 8'h00;
               hora_d = bcd_inc(hora_q);
               if (hora_q == 8'h23) begin
                  hora_d = 8'h00;
                  date_d = bcd_inc(date_q);
                  if (date_q == mlen_c) begin
                     date_d = 8'h01;
                     mes_d  = bcd_inc(mes_q);
                     if (mes_q == 8'h12) begin
                        mes_d = 8'h01;
                        ano_d = (ano_q == 8'h99) ? 8'h00 : bcd_inc(ano_q);
                     end
                  end
               end
            end
         end

         if ({thora_q, tmin_q, tseg_q} != 24'h000000) begin
            tseg_d = bcd_dec(tseg_q);
            if (tseg_q == 8'h00) begin
               tseg_d = 8'h59;
               tmin_d = bcd_dec(tmin_q);
               if (tmin_q == 8'h00) begin
                  tmin_d  = 8'h59;
                  thora_d = bcd_dec(thora_q);
               end
            end
            if ({thora_q, tmin_q, tseg_q} == 24'h000001) done_d = 1'b1;
         end
      end

      // Bus write lands last so it overrides the tick for its own register
      if (commit_c) begin
         if (!ad_s) begin
            addr_d = bus_i;
         end else begin
            case (addr_q)
               8'h21:   seg_d   = bus_i;
               8'h22:   min_d   = bus_i;
               8'h23:   hora_d  = bus_i;
               8'h24:   date_d  = bus_i;
               8'h25:   mes_d   = bus_i;
               8'h26:   ano_d   = bus_i;
               8'h41:   tseg_d  = bus_i;
               8'h42:   tmin_d  = bus_i;
               8'h43:   thora_d = bus_i;
               8'hF1:   done_d  = 1'b0;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cs_sync_q <= '1;
         rd_sync_q <= '1;
         wr_sync_q <= '1;
         ad_sync_q <= '0;
         wr_prev_q <= 1'b1;
         presc_q   <= '0;
         addr_q    <= 8'h00;
         seg_q     <= 8'h00;
         min_q     <= 8'h00;
         hora_q    <= 8'h00;
         date_q    <= 8'h01;
         mes_q     <= 8'h01;
         ano_q     <= 8'h00;
         tseg_q    <= 8'h00;
         tmin_q    <= 8'h00;
         thora_q   <= 8'h00;
         done_q    <= 1'b0;
         oe_q      <= 1'b0;
         bus_q     <= 8'h00;
      end else begin
         cs_sync_q <= cs_sync_d;
         rd_sync_q <= rd_sync_d;
         wr_sync_q <= wr_sync_d;
         ad_sync_q <= ad_sync_d;
         wr_prev_q <= wr_prev_d;
         presc_q   <= presc_d;
         addr_q    <= addr_d;
         seg_q     <= seg_d;
         min_q     <= min_d;
         hora_q    <= hora_d;
         date_q    <= date_d;
         mes_q     <= mes_d;
         ano_q     <= ano_d;
         tseg_q    <= tseg_d;
         tmin_q    <= tmin_d;
         thora_q   <= thora_d;
         done_q    <= done_d;
         oe_q      <= oe_d;
         bus_q     <= bus_d;
      end
   end

   assign bus_o        = bus_q;
   assign bus_oe_o     = oe_q;
   assign timer_done_o = done_q;
   assign regseg       = seg_q;
   assign regmin       = min_q;
   assign reghora      = hora_q;
   assign regdate      = date_q;
   assign regmes       = mes_q;
   assign regano       = ano_q;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Bench for rtc_bus_responder: calendar/timer model in whole seconds and days,
// checked every cycle, plus directed bus transactions with literal expectations.
module tb_rtc_bus_responder;
   localparam int TD = 250;
   localparam int SS = 2;
   localparam int HL = SS + 2;

   logic       clk = 1'b0;
   logic       reset, cs_n, ad, rd_n, wr_n;
   logic [7:0] bus_in, bus_out;
   logic       bus_oe, done;
   logic [7:0] regseg, regmin, reghora, regdate, regmes, regano;

   int n_tests = 0;
   int n_fail  = 0;
   bit run_chk = 0;

   always #5 clk = ~clk;

   rtc_bus_responder #(.TICK_DIV(TD), .SYNC_STG(SS)) dut (
      .clk_i(clk), .reset_i(reset), .cs_n_i(cs_n), .ad_i(ad), .rd_n_i(rd_n),
      .wr_n_i(wr_n), .bus_i(bus_in), .bus_o(bus_out), .bus_oe_o(bus_oe),
      .timer_done_o(done), .regseg(regseg), .regmin(regmin), .reghora(reghora),
      .regdate(regdate), .regmes(regmes), .regano(regano)
   );

   // Model state in plain integers
   int         m_sec, m_min, m_hr, m_dt, m_mo, m_yr, m_ts, m_tm, m_th, m_cnt;
   bit         m_done, m_oe, m_tick;
   logic [7:0] m_addr, m_bus;
   bit         h_cs[HL], h_rd[HL], h_wr[HL], h_ad[HL];

   function automatic logic [7:0] tobcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   function automatic int frombcd(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic int mdays(input int mo, input int yr);
      case (mo)
         2:           return (yr % 4 == 0) ? 29 : 28;
         4, 6, 9, 11: return 30;
         default:     return 31;
      endcase
   endfunction

   function automatic logic [7:0] m_read(input logic [7:0] a);
      case (a)
         8'h21:   return tobcd(m_sec);
         8'h22:   return tobcd(m_min);
         8'h23:   return tobcd(m_hr);
         8'h24:   return tobcd(m_dt);
         8'h25:   return tobcd(m_mo);
         8'h26:   return tobcd(m_yr);
         8'h41:   return tobcd(m_ts);
         8'h42:   return tobcd(m_tm);
         8'h43:   return tobcd(m_th);
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_step();
      bit commit, sel;
      int s, t;
      if (reset) begin
         m_sec = 0; m_min = 0; m_hr = 0; m_dt = 1; m_mo = 1; m_yr = 0;
         m_ts = 0; m_tm = 0; m_th = 0; m_cnt = 0;
         m_done = 0; m_oe = 0; m_tick = 0; m_addr = 8'h00; m_bus = 8'h00;
         for (int k = 0; k < HL; k++) begin
            h_cs[k] = 1; h_rd[k] = 1; h_wr[k] = 1; h_ad[k] = 0;
         end
         return;
      end
      // strobes seen by the device are the pins delayed by SS cycles
      for (int k = HL - 1; k > 0; k--) begin
         h_cs[k] = h_cs[k-1]; h_rd[k] = h_rd[k-1];
         h_wr[k] = h_wr[k-1]; h_ad[k] = h_ad[k-1];
      end
      h_cs[0] = cs_n; h_rd[0] = rd_n; h_wr[0] = wr_n; h_ad[0] = ad;
      commit = h_wr[SS] && !h_wr[SS+1] && !h_cs[SS];
      sel    = !h_cs[SS] && !h_rd[SS] && h_ad[SS] && h_wr[SS];
      if (sel && !m_oe) m_bus = m_read(m_addr);
      m_oe   = sel;
      m_tick = (m_cnt == TD - 1);
      m_cnt  = m_tick ? 0 : m_cnt + 1;
      if (m_tick) begin
         s = m_hr * 3600 + m_min * 60 + m_sec + 1;
         if (s == 86400) begin
            s = 0;
            m_dt = m_dt + 1;
            if (m_dt > mdays(m_mo, m_yr)) begin
               m_dt = 1;
               m_mo = m_mo + 1;
               if (m_mo > 12) begin
                  m_mo = 1;
                  m_yr = (m_yr + 1) % 100;
               end
            end
         end
         m_hr = s / 3600; m_min = (s / 60) % 60; m_sec = s % 60;
         t = m_th * 3600 + m_tm * 60 + m_ts;
         if (t > 0) begin
            t = t - 1;
            if (t == 0) m_done = 1;
            m_th = t / 3600; m_tm = (t / 60) % 60; m_ts = t % 60;
         end
      end
      if (commit) begin
         if (!h_ad[SS]) m_addr = bus_in;
         else begin
            case (m_addr)
               8'h21:   m_sec = frombcd(bus_in);
               8'h22:   m_min = frombcd(bus_in);
               8'h23:   m_hr  = frombcd(bus_in);
               8'h24:   m_dt  = frombcd(bus_in);
               8'h25:   m_mo  = frombcd(bus_in);
               8'h26:   m_yr  = frombcd(bus_in);
               8'h41:   m_ts  = frombcd(bus_in);
               8'h42:   m_tm  = frombcd(bus_in);
               8'h43:   m_th  = frombcd(bus_in);
               8'hF1:   m_done = 0;
               default: ;
            endcase
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (run_chk) begin
         chk("seg", regseg, tobcd(m_sec));
         chk("min", regmin, tobcd(m_min));
         chk("hora", reghora, tobcd(m_hr));
         chk("date", regdate, tobcd(m_dt));
         chk("mes", regmes, tobcd(m_mo));
         chk("ano", regano, tobcd(m_yr));
         chk("timer_done", 8'(done), 8'(m_done));
         chk("bus_oe", 8'(bus_oe), 8'(m_oe));
         if (m_oe) chk("bus_o", bus_out, m_bus);
      end
   end

   task automatic bus_write(input logic a, input logic [7:0] d, input logic cs);
      @(negedge clk); cs_n = cs; ad = a; bus_in = d;
      repeat (3) @(negedge clk); wr_n = 1'b0;
      repeat (4) @(negedge clk); wr_n = 1'b1;
      repeat (4) @(negedge clk); cs_n = 1'b1;
   endtask

   task automatic bus_read(input logic a, input logic cs, input logic wr_too,
                           input logic [7:0] din, output logic [7:0] d, output logic oe_seen);
      @(negedge clk); cs_n = cs; ad = a; bus_in = din; oe_seen = 1'b0;
      repeat (3) @(negedge clk); rd_n = 1'b0; if (wr_too) wr_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         oe_seen = oe_seen | bus_oe;
      end
      d = bus_out;
      rd_n = 1'b1; wr_n = 1'b1;
      repeat (4) @(negedge clk); cs_n = 1'b1;
   endtask

   task automatic wait_tick();
      bit got = 0;
      for (int i = 0; i < TD + 10 && !got; i++) begin
         @(negedge clk);
         if (m_tick) got = 1;
      end
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL tick_wait: no tick within %0d cycles", TD + 10);
      end
   endtask

   task automatic set_reg(input logic [7:0] a, input logic [7:0] d);
      bus_write(1'b0, a, 1'b0);
      bus_write(1'b1, d, 1'b0);
   endtask

   logic [7:0] rd_data;
   logic       rd_oe;
   bit         found;

   initial begin
      reset = 1'b1; cs_n = 1'b1; ad = 1'b0; rd_n = 1'b1; wr_n = 1'b1; bus_in = 8'h00;
      repeat (3) @(negedge clk);
      run_chk = 1;
      reset = 1'b0;
      chk("rst_seg", regseg, 8'h00);
      chk("rst_date", regdate, 8'h01);
      chk("rst_mes", regmes, 8'h01);
      chk("rst_ano", regano, 8'h00);
      chk("rst_bus_o", bus_out, 8'h00);
      chk("rst_oe", 8'(bus_oe), 8'h00);
      chk("rst_done", 8'(done), 8'h00);

      // minute register write and read-back
      set_reg(8'h22, 8'h45);
      chk("t1_regmin", regmin, 8'h45);
      bus_read(1'b1, 1'b0, 1'b0, 8'h00, rd_data, rd_oe);
      chk("t1_read_data", rd_data, 8'h45);
      chk("t1_read_oe", 8'(rd_oe), 8'h01);
      bus_read(1'b0, 1'b0, 1'b0, 8'h22, rd_data, rd_oe);
      chk("t1_addr_phase_oe", 8'(rd_oe), 8'h00);

      // unmapped read, RD+WR collision, deselected strobes
      bus_write(1'b0, 8'h30, 1'b0);
      bus_read(1'b1, 1'b0, 1'b0, 8'h00, rd_data, rd_oe);
      chk("t5_unmapped_data", rd_data, 8'h00);
      chk("t5_unmapped_oe", 8'(rd_oe), 8'h01);
      bus_write(1'b0, 8'h26, 1'b0);
      bus_read(1'b1, 1'b0, 1'b1, 8'h42, rd_data, rd_oe);
      chk("t5_rdwr_oe", 8'(rd_oe), 8'h00);
      chk("t5_rdwr_ano", regano, 8'h42);
      bus_write(1'b0, 8'h22, 1'b1);
      bus_write(1'b1, 8'h11, 1'b1);
      chk("t5_cs_hi_min", regmin, 8'h45);
      bus_read(1'b1, 1'b1, 1'b0, 8'h00, rd_data, rd_oe);
      chk("t5_cs_hi_oe", 8'(rd_oe), 8'h00);

      // end-of-century rollover
      wait_tick();
      set_reg(8'h23, 8'h23); set_reg(8'h22, 8'h59); set_reg(8'h21, 8'h59);
      set_reg(8'h24, 8'h31); set_reg(8'h25, 8'h12); set_reg(8'h26, 8'h99);
      wait_tick();
      chk("t2_seg", regseg, 8'h00);
      chk("t2_min", regmin, 8'h00);
      chk("t2_hora", reghora, 8'h00);
      chk("t2_date", regdate, 8'h01);
      chk("t2_mes", regmes, 8'h01);
      chk("t2_ano", regano, 8'h00);

      // February in leap and non-leap years
      wait_tick();
      set_reg(8'h23, 8'h23); set_reg(8'h22, 8'h59); set_reg(8'h21, 8'h59);
      set_reg(8'h24, 8'h28); set_reg(8'h25, 8'h02); set_reg(8'h26, 8'h24);
      wait_tick();
      chk("t3_leap_date", regdate, 8'h29);
      chk("t3_leap_mes", regmes, 8'h02);
      wait_tick();
      set_reg(8'h23, 8'h23); set_reg(8'h22, 8'h59); set_reg(8'h21, 8'h59);
      set_reg(8'h24, 8'h28); set_reg(8'h26, 8'h23);
      wait_tick();
      chk("t3_noleap_date", regdate, 8'h01);
      chk("t3_noleap_mes", regmes, 8'h03);

      // one-minute countdown
      wait_tick();
      set_reg(8'h42, 8'h01);
      for (int i = 0; i < 60; i++) begin
         wait_tick();
         if (i == 58) chk("t4_done_early", 8'(done), 8'h00);
      end
      chk("t4_done", 8'(done), 8'h01);
      bus_write(1'b0, 8'h41, 1'b0);
      bus_read(1'b1, 1'b0, 1'b0, 8'h00, rd_data, rd_oe);
      chk("t4_tseg", rd_data, 8'h00);
      bus_write(1'b0, 8'h42, 1'b0);
      bus_read(1'b1, 1'b0, 1'b0, 8'h00, rd_data, rd_oe);
      chk("t4_tmin", rd_data, 8'h00);
      wait_tick();
      chk("t4_done_held", 8'(done), 8'h01);
      set_reg(8'hF1, 8'h5A);
      chk("t4_done_clr", 8'(done), 8'h00);

      // write to seg committed on the tick edge
      wait_tick();
      set_reg(8'h22, 8'h33);
      set_reg(8'h21, 8'h00);
      @(negedge clk); cs_n = 1'b0; ad = 1'b1; bus_in = 8'h10;
      repeat (2) @(negedge clk); wr_n = 1'b0;
      found = 0;
      for (int i = 0; i < TD + 10 && !found; i++) begin
         @(negedge clk);
         if (m_cnt == TD - 1 - SS) found = 1;
      end
      wr_n = 1'b1;
      repeat (SS + 1) @(negedge clk);
      chk("t6_tick_phase", 8'(found), 8'h01);
      chk("t6_seg", regseg, 8'h10);
      chk("t6_min", regmin, 8'h33);
      cs_n = 1'b1;

      // reset in the middle of a read
      bus_write(1'b0, 8'h22, 1'b0);
      @(negedge clk); cs_n = 1'b0; ad = 1'b1;
      repeat (2) @(negedge clk); rd_n = 1'b0;
      repeat (5) @(negedge clk);
      chk("t6_oe_before_rst", 8'(bus_oe), 8'h01);
      reset = 1'b1;
      @(negedge clk);
      chk("t6_rst_oe", 8'(bus_oe), 8'h00);
      chk("t6_rst_bus_o", bus_out, 8'h00);
      chk("t6_rst_min", regmin, 8'h00);
      chk("t6_rst_date", regdate, 8'h01);
      chk("t6_rst_done", 8'(done), 8'h00);
      cs_n = 1'b1; rd_n = 1'b1;
      @(negedge clk); reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("t6_after_rst_oe", 8'(bus_oe), 8'h00);

      run_chk = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
